// File: rtl/gate_chk_pkg.sv
// Shared types and reference truth tables for the exhaustive gate checker.
// Truth-table bit i is the expected gate output for input vector i.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_e;

    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_NOR2  = 4'b0001;
    localparam logic [3:0] TT_XNOR2 = 4'b1001;

endpackage

// File: rtl/gate_chk_vec_gen.sv
// Input-vector counter for the gate checker: cleared on load, stepped on inc,
// and flags the all-ones vector so the run can stop without wrapping.
module gate_chk_vec_gen #(
    parameter int N_IN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            inc,
    output logic [N_IN-1:0] vec,
    output logic            is_last
);

    logic [N_IN-1:0] vec_r;

    // Vector register: load wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_r <= {N_IN{1'b0}};
        end else if (load) begin
            vec_r <= {N_IN{1'b0}};
        end else if (inc) begin
            vec_r <= vec_r + {{(N_IN-1){1'b0}}, 1'b1};
        end else begin
            vec_r <= vec_r;
        end
    end

    assign vec     = vec_r;
    assign is_last = (vec_r == {N_IN{1'b1}});

endmodule

// File: rtl/gate_exhaustive_checker.sv
// Walks every input vector of a small gate, samples its output after a settle
// delay and scores it against EXP_TT (error count, first failing vector, pass).
module gate_exhaustive_checker #(
    parameter int                      N_IN   = 2,
    parameter int                      SETTLE = 1,
    parameter logic [(1 << N_IN)-1:0]  EXP_TT = gate_chk_pkg::TT_OR2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dut_op,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    import gate_chk_pkg::*;

    // Counter only ever holds SETTLE-1 down to 0
    localparam int            CW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE - 1);

    state_e          state_r;
    logic [CW-1:0]   cnt_r;
    logic            busy_r;
    logic            done_r;
    logic            pass_r;
    logic [N_IN:0]   err_r;
    logic [N_IN-1:0] ffvec_r;
    logic            ffvalid_r;

    logic [N_IN-1:0] vec_s;
    logic            is_last_s;
    logic            load_s;
    logic            inc_s;
    logic            mismatch_s;
    logic [N_IN:0]   err_next_s;

    gate_chk_vec_gen #(
        .N_IN (N_IN)
    ) u_vec_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load_s),
        .inc     (inc_s),
        .vec     (vec_s),
        .is_last (is_last_s)
    );

    // Vector-counter control and the score for the vector being sampled
    always_comb begin
        load_s     = 1'b0;
        inc_s      = 1'b0;
        mismatch_s = 1'b0;
        err_next_s = err_r;
        case (state_r)
            gate_chk_pkg::IDLE: begin
                load_s = start;
            end
            gate_chk_pkg::SAMPLE: begin
                mismatch_s = (dut_op != EXP_TT[vec_s]);
                err_next_s = err_r + {{N_IN{1'b0}}, mismatch_s};
                inc_s      = ~is_last_s;
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Run FSM, settle timer and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= gate_chk_pkg::IDLE;
            cnt_r     <= {CW{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            err_r     <= {(N_IN+1){1'b0}};
            ffvec_r   <= {N_IN{1'b0}};
            ffvalid_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                gate_chk_pkg::IDLE: begin
                    if (start) begin
                        err_r     <= {(N_IN+1){1'b0}};
                        ffvec_r   <= {N_IN{1'b0}};
                        ffvalid_r <= 1'b0;
                        pass_r    <= 1'b0;
                        cnt_r     <= CNT_RELOAD;
                        busy_r    <= 1'b1;
                        state_r   <= gate_chk_pkg::SETTLE;
                    end
                end
                gate_chk_pkg::SETTLE: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= gate_chk_pkg::SAMPLE;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                gate_chk_pkg::SAMPLE: begin
                    err_r <= err_next_s;
                    if (mismatch_s && !ffvalid_r) begin
                        ffvec_r   <= vec_s;
                        ffvalid_r <= 1'b1;
                    end
                    // Last vector stays on vec_out; pass includes this cycle's mismatch
                    if (is_last_s) begin
                        state_r <= gate_chk_pkg::IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        pass_r  <= (err_next_s == {(N_IN+1){1'b0}});
                    end else begin
                        cnt_r   <= CNT_RELOAD;
                        state_r <= gate_chk_pkg::SETTLE;
                    end
                end
                default: begin
                    state_r <= gate_chk_pkg::IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign vec_out          = vec_s;
    assign busy             = busy_r;
    assign done             = done_r;
    assign pass             = pass_r;
    assign err_count        = err_r;
    assign first_fail_vec   = ffvec_r;
    assign first_fail_valid = ffvalid_r;

endmodule

// File: tb/tb_gate_exhaustive_checker.sv
// Scoreboard bench for gate_exhaustive_checker: three checker instances drive
// behavioural gates; expected results come from a truth-table model.
module tb_gate_exhaustive_checker;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] start = 3'b000;
    logic [2:0] op;
    logic [2:0] busy, done, pass, ffvalid;
    logic [1:0] vec_a, vec_b, ff_a, ff_b;
    logic [2:0] vec_c, ff_c, err_a, err_b;
    logic [3:0] err_c;

    int         vec    [3];
    int         errc   [3];
    int         ffvec  [3];
    int         mode   [3] = '{0, 0, 0};
    logic [7:0] rtab   [3] = '{8'h00, 8'h00, 8'h00};
    int         n_in   [3] = '{2, 2, 3};
    int         settle [3] = '{1, 1, 2};
    logic [7:0] exp_tt [3] = '{8'h0E, 8'h08, 8'h96};

    typedef struct {
        int id;
        int errs;
        int ffv;
        int ffvalid;
        int pass;
        int blen;
    } exp_t;

    exp_t sb [$];
    exp_t e;
    int   bcnt [3] = '{0, 0, 0};
    int   total = 0;
    int   bad   = 0;
    int   ri;
    int   k;

    always #5 clk = ~clk;

    gate_exhaustive_checker #(.N_IN(2), .SETTLE(1), .EXP_TT(gate_chk_pkg::TT_OR2)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .dut_op(op[0]), .vec_out(vec_a),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_a),
        .first_fail_vec(ff_a), .first_fail_valid(ffvalid[0]));

    gate_exhaustive_checker #(.N_IN(2), .SETTLE(1), .EXP_TT(gate_chk_pkg::TT_AND2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .dut_op(op[1]), .vec_out(vec_b),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_b),
        .first_fail_vec(ff_b), .first_fail_valid(ffvalid[1]));

    gate_exhaustive_checker #(.N_IN(3), .SETTLE(2), .EXP_TT(8'b10010110)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .dut_op(op[2]), .vec_out(vec_c),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err_c),
        .first_fail_vec(ff_c), .first_fail_valid(ffvalid[2]));

    always_comb begin
        vec[0]   = int'(vec_a);
        vec[1]   = int'(vec_b);
        vec[2]   = int'(vec_c);
        errc[0]  = int'(err_a);
        errc[1]  = int'(err_b);
        errc[2]  = int'(err_c);
        ffvec[0] = int'(ff_a);
        ffvec[1] = int'(ff_b);
        ffvec[2] = int'(ff_c);
    end

    // Behavioural gate: 0=OR 1=AND 2=XOR 3=stuck0 4=stuck1 else random table
    function automatic logic gate_eval(int m, int v, int n, logic [7:0] rt);
        case (m)
            0:       return v != 0;
            1:       return v == ((1 << n) - 1);
            2:       return ($countones(v) % 2) == 1;
            3:       return 1'b0;
            4:       return 1'b1;
            default: return rt[v];
        endcase
    endfunction

    always_comb begin
        op = 3'b000;
        for (int i = 0; i < 3; i++) op[i] = gate_eval(mode[i], vec[i], n_in[i], rtab[i]);
    end

    function automatic exp_t model(int i);
        exp_t r;
        r.id = i; r.errs = 0; r.ffv = 0; r.ffvalid = 0;
        for (int v = 0; v < (1 << n_in[i]); v++) begin
            if (gate_eval(mode[i], v, n_in[i], rtab[i]) != exp_tt[i][v]) begin
                if (r.errs == 0) begin
                    r.ffv     = v;
                    r.ffvalid = 1;
                end
                r.errs++;
            end
        end
        r.pass = (r.errs == 0) ? 1 : 0;
        r.blen = (1 << n_in[i]) * (settle[i] + 1);
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic int out_sum(int i);
        return vec[i] + errc[i] + ffvec[i] + int'(busy[i]) + int'(done[i])
             + int'(pass[i]) + int'(ffvalid[i]);
    endfunction

    // Monitor: vector sequence while busy, results popped on every done pulse
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                bcnt[i] = 0;
            end else begin
                if (busy[i]) begin
                    chk("vec_seq", vec[i], bcnt[i] / (settle[i] + 1));
                    bcnt[i]++;
                end
                if (done[i]) begin
                    if (sb.size() == 0 || sb[0].id != i) begin
                        chk("unexpected_done", int'(done[i]), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("err_count", errc[i], e.errs);
                        chk("first_fail_valid", int'(ffvalid[i]), e.ffvalid);
                        chk("first_fail_vec", ffvec[i], e.ffv);
                        chk("pass", int'(pass[i]), e.pass);
                        chk("busy_len", bcnt[i], e.blen);
                        chk("vec_hold", vec[i], (1 << n_in[i]) - 1);
                    end
                    bcnt[i] = 0;
                end
            end
        end
    end

    task automatic wait_done(input int i, input bit noisy);
        int n;
        for (n = 0; n < 300; n++) begin
            @(posedge clk); #3;
            if (done[i]) break;
            if (noisy) start[i] = busy[i] ? 1'($urandom % 2) : 1'b0;
        end
        if (noisy) start[i] = 1'b0;
        if (n == 300) chk("done_timeout", n, 0);
    endtask

    task automatic run_once(input int i, input int m, input bit noisy);
        mode[i] = m;
        sb.push_back(model(i));
        start[i] = 1'b1;
        @(posedge clk); #3;
        start[i] = 1'b0;
        wait_done(i, noisy);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk("reset_outputs", out_sum(i), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        run_once(0, 0, 1'b0);
        run_once(0, 3, 1'b0);
        run_once(0, 1, 1'b0);
        run_once(1, 1, 1'b0);
        run_once(2, 2, 1'b0);

        // start held high: three back-to-back runs
        mode[0] = 0;
        repeat (3) sb.push_back(model(0));
        start[0] = 1'b1;
        wait_done(0, 1'b0);
        @(posedge clk); #3;
        chk("b2b_busy", int'(busy[0]), 1);
        wait_done(0, 1'b0);
        @(posedge clk); #3;
        chk("b2b_busy", int'(busy[0]), 1);
        start[0] = 1'b0;
        wait_done(0, 1'b0);

        // start pulses while busy must not queue extra runs
        run_once(0, 0, 1'b1);
        repeat (4) begin @(posedge clk); #3; end

        // asynchronous reset mid-run at vector 2'b10
        mode[0] = 0;
        sb.push_back(model(0));
        start[0] = 1'b1;
        @(posedge clk); #3;
        start[0] = 1'b0;
        for (k = 0; k < 50; k++) begin
            if (vec[0] == 2) break;
            @(posedge clk); #3;
        end
        chk("reached_vec2", vec[0], 2);
        #1 rst_n = 1'b0;
        #1;
        chk("midrun_reset", out_sum(0), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #3; end
        run_once(0, 0, 1'b0);

        // randomized gates, instances and start noise
        for (int r = 0; r < 24; r++) begin
            ri = $urandom_range(2, 0);
            rtab[ri] = 8'($urandom);
            run_once(ri, $urandom_range(5, 0), 1'($urandom % 2));
            repeat ($urandom_range(3, 0)) begin @(posedge clk); #3; end
        end

        repeat (4) begin @(posedge clk); #3; end
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_exhaustive_checker.md
Name: gate_exhaustive_checker

Overview:
Self-checking stimulus stage that sits directly upstream of a small combinational gate under test (OR, AND, XOR, ...). On a start pulse it walks every input combination in ascending binary order on vec_out. After a settle delay it samples the gate's output and compares it with a parameterised expected truth table. It reports the error count, the first failing vector and a pass flag. This replaces hand-written per-gate stimulus sequences in lab benches and on-board checks.

Parameters:
N_IN, 2, number of gate inputs; 1..4 supported.
SETTLE, 1, wait cycles between driving a vector and sampling dut_op; must be >= 1.
EXP_TT, 4'b1110, expected truth table, width 2**N_IN; bit i = expected output for input vector i (default = 2-input OR).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  run request; sampled only in IDLE
dut_op  input  1  output of the gate under test
vec_out  output  N_IN  input vector driven to the gate; bit 0 = input1, bit 1 = input2, ...
busy  output  1  high while a run is in progress
done  output  1  one-cycle pulse at end of run
pass  output  1  1 when last completed run had zero errors; held until next start
err_count  output  N_IN+1  mismatches in current/last run (max 2**N_IN)
first_fail_vec  output  N_IN  vector of first mismatch in run
first_fail_valid  output  1  first_fail_vec is meaningful

Behaviour:
- Interface fixed: single clock clk; reset rst_n is asynchronous, active-low. All state flops are cleared on the falling edge of rst_n.
- Reset values: vec_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0, state=IDLE, settle counter=0.
- All outputs are registered. No combinational path from dut_op or start to any output.
- FSM states:
  - IDLE: done=0 except on the first IDLE cycle after a run. When start=1 at a clock edge: vec_out<=0, err_count<=0, first_fail_valid<=0, first_fail_vec<=0, pass<=0, settle counter<=SETTLE-1, busy<=1, go to SETTLE.
  - SETTLE: decrements the counter each cycle. When the counter reaches 0, go to SAMPLE.
  - SAMPLE: compare dut_op with EXP_TT[vec_out].
    - On mismatch: err_count++. If first_fail_valid=0, first_fail_vec<=vec_out and first_fail_valid<=1.
    - If vec_out==2**N_IN-1: go to IDLE, busy<=0, done<=1 for one cycle. pass<=1 when the final err_count is 0, including the mismatch counted this cycle.
    - Otherwise: vec_out<=vec_out+1, reload counter to SETTLE-1, go to SETTLE.
- Timing: each vector occupies SETTLE+1 cycles. busy stays high for exactly 2**N_IN*(SETTLE+1) cycles. done rises on the first cycle busy is low.
- start while busy is ignored. No queuing.
- start high on the done cycle (IDLE) begins a new run immediately. Back-to-back runs are legal.
- vec_out holds its last value (all ones) after a run until the next start. It does not wrap to 0 at the end.
- err_count cannot overflow: its width covers 2**N_IN.
- Reset asserted mid-run: immediate abort, all outputs return to reset values, no done pulse. The next start after reset release runs cleanly.
- dut_op is assumed synchronous to clk, driven combinationally from vec_out. No synchroniser.

Decomposition:
- Package gate_chk_pkg holds:
  - state enum typedef {IDLE, SETTLE, SAMPLE};
  - truth-table constants TT_OR2=4'b1110, TT_AND2=4'b1000, TT_XOR2=4'b0110, TT_NAND2=4'b0111, TT_NOR2=4'b0001, TT_XNOR2=4'b1001.
- One sub-module is natural: gate_chk_vec_gen, the vector counter with load/increment and an is_last flag.
- FSM, settle timer and score logic stay in the top module.

Test Plan:
- Correct 2-input OR on vec_out, EXP_TT=TT_OR2, SETTLE=1, start pulse -> busy high 8 cycles, vec_out sequence 00,01,10,11 (2 cycles each), done pulse, pass=1, err_count=0, first_fail_valid=0.
- dut_op tied 0, EXP_TT=TT_OR2 -> err_count=3, first_fail_vec=2'b01, first_fail_valid=1, pass=0.
- AND gate as DUT, EXP_TT=TT_OR2 -> err_count=2, first_fail_vec=2'b01, pass=0. Then swap EXP_TT=TT_AND2 and rerun -> pass=1, err_count=0.
- start held high continuously with correct OR -> consecutive runs, each 8 busy cycles separated by one done/IDLE cycle. start pulses during busy produce no extra runs.
- rst_n low while vec_out=2'b10 -> all outputs 0 asynchronously, no done pulse. After release plus a start -> a full clean run, pass=1.
- N_IN=3, SETTLE=2, 3-input XOR DUT with EXP_TT=8'b10010110 -> busy 24 cycles, pass=1, err_count=0.
